baggage_drop_ctrl: RTL



---
 rtl/baggage_drop_ctrl.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/baggage_drop_ctrl.sv
// ---------------------------------------------------------------------------
// baggage_drop_ctrl
//
// Purpose:
//   Clocked baggage-drop controller. Compares the measured temperature against
//   a limit, runs a timed drop sequence (fixed-length actuator pulse followed
//   by a completion message), enforces a re-arm interlock so that a held
//   drop request cannot fire twice, and drives four seven-segment digits.
//
// Optional feature (compile-time macro):
//   BAGGAGE_HOT_LOCKOUT_EN - counts drop attempts made while too hot. After
//   LOCK_TRIES such attempts the controller locks up (shows LOC) until reset.
//
// Parameters:
//   T_WIDTH     - width of t_act / t_lim
//   DROP_CYCLES - cycles drop_activated is held high per drop (>= 1)
//   DONE_CYCLES - cycles the dOnE message is shown after a drop (>= 1)
//   LOCK_TRIES  - hot attempts before lockout (>= 1, lockout build only)
//
// Ports:
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   t_act          in   measured temperature, unsigned
//   t_lim          in   temperature limit, unsigned
//   drop_en        in   drop request, level sensitive
//   seven_seg1..4  out  digits left to right, bit order {g,f,e,d,c,b,a},
//                       1 = segment lit
//   drop_activated out  actuator pulse
//   busy           out  high while dropping or showing dOnE
//
// All outputs are registered and reflect the state entered at the most
// recent clock edge.
// ---------------------------------------------------------------------------
module baggage_drop_ctrl #(
  parameter int unsigned T_WIDTH     = 16,
  parameter int unsigned DROP_CYCLES = 8,
  parameter int unsigned DONE_CYCLES = 4,
  parameter int unsigned LOCK_TRIES  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [T_WIDTH-1:0] t_act,
  input  logic [T_WIDTH-1:0] t_lim,
  input  logic               drop_en,
  output logic [6:0]         seven_seg1,
  output logic [6:0]         seven_seg2,
  output logic [6:0]         seven_seg3,
  output logic [6:0]         seven_seg4,
  output logic               drop_activated,
  output logic               busy
);

  // -------------------------------------------------------------------------
  // Counter sizing: wide enough to hold the larger of the two load values
  // plus one, so the loaded value never wraps.
  // -------------------------------------------------------------------------
  localparam int unsigned MAX_CYC = (DROP_CYCLES > DONE_CYCLES) ? DROP_CYCLES : DONE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] DROP_LOAD = CNT_W'(DROP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DONE_LOAD = CNT_W'(DONE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // -------------------------------------------------------------------------
  // States
  // -------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DROP = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
`ifdef BAGGAGE_HOT_LOCKOUT_EN
  localparam logic [1:0] ST_LOCK = 2'd3;
`endif

  // -------------------------------------------------------------------------
  // Glyphs, bit order {g,f,e,d,c,b,a}
  // -------------------------------------------------------------------------
  localparam logic [6:0] G_BLANK = 7'b0000000;
  localparam logic [6:0] G_H     = 7'b1110110;
  localparam logic [6:0] G_O     = 7'b1011100;
  localparam logic [6:0] G_T     = 7'b1111000;
  localparam logic [6:0] G_C     = 7'b0111001;
  localparam logic [6:0] G_L     = 7'b0111000;
  localparam logic [6:0] G_D     = 7'b1011110;
  localparam logic [6:0] G_R     = 7'b1010000;
  localparam logic [6:0] G_P     = 7'b1110011;
  localparam logic [6:0] G_N     = 7'b1010100;
  localparam logic [6:0] G_E     = 7'b1111001;
  localparam logic [6:0] G_DASH  = 7'b1000000;

  // Messages packed as {digit1, digit2, digit3, digit4}
  localparam logic [27:0] MSG_HOT  = {G_BLANK, G_H, G_O, G_T};
  localparam logic [27:0] MSG_COLD = {G_C, G_O, G_L, G_D};
  localparam logic [27:0] MSG_DROP = {G_D, G_R, G_O, G_P};
  localparam logic [27:0] MSG_DONE = {G_D, G_O, G_N, G_E};
  localparam logic [27:0] MSG_WAIT = {G_DASH, G_DASH, G_DASH, G_DASH};
  localparam logic [27:0] MSG_OFF  = {G_BLANK, G_BLANK, G_BLANK, G_BLANK};
`ifdef BAGGAGE_HOT_LOCKOUT_EN
  localparam logic [27:0] MSG_LOC  = {G_L, G_O, G_C, G_BLANK};
`endif

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_armed;
  logic [27:0]      r_msg;
  logic             r_drop_act;
  logic             r_busy;

  logic [1:0]       w_state_d;
  logic [CNT_W-1:0] w_cnt_d;
  logic             w_armed_d;
  logic [27:0]      w_msg_d;
  logic             w_ok;
  logic             w_cnt_zero;
  logic             w_drop_start;

`ifdef BAGGAGE_HOT_LOCKOUT_EN
  localparam int unsigned    TRY_W     = $clog2(LOCK_TRIES + 1);
  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(LOCK_TRIES);
  localparam logic [TRY_W-1:0] TRY_ONE   = TRY_W'(1);

  logic [TRY_W-1:0] r_tries;
  logic [TRY_W-1:0] w_tries_d;
  logic             r_drop_en_prev;
  logic             w_hot_attempt;
`else
  // LOCK_TRIES only matters for the lockout build.
  logic w_unused_lock_tries;
  assign w_unused_lock_tries = ^LOCK_TRIES;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_ok         = (t_act <= t_lim);
    w_cnt_zero   = (r_cnt == '0);
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_drop_start = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (drop_en && w_ok && r_armed) begin
          w_state_d    = ST_DROP;
          w_cnt_d      = DROP_LOAD;
          w_drop_start = 1'b1;
        end
      end
      ST_DROP: begin
        if (w_cnt_zero) begin
          w_state_d = ST_DONE;
          w_cnt_d   = DONE_LOAD;
        end else begin
          w_cnt_d = r_cnt - CNT_ONE;
        end
      end
      ST_DONE: begin
        if (w_cnt_zero) begin
          w_state_d = ST_IDLE;
        end else begin
          w_cnt_d = r_cnt - CNT_ONE;
        end
      end
`ifdef BAGGAGE_HOT_LOCKOUT_EN
      ST_LOCK: begin
        w_state_d = ST_LOCK;
      end
`endif
      default: begin
        w_state_d = ST_IDLE;
        w_cnt_d   = '0;
      end
    endcase

`ifdef BAGGAGE_HOT_LOCKOUT_EN
    // A hot attempt is a fresh press of drop_en while idle and too hot.
    w_hot_attempt = (r_state == ST_IDLE) && drop_en && !r_drop_en_prev && !w_ok;
    w_tries_d     = r_tries;
    if (w_drop_start) begin
      w_tries_d = '0;
    end else if (w_hot_attempt) begin
      if (r_tries != TRY_LIMIT) begin
        w_tries_d = r_tries + TRY_ONE;
      end
      if (w_tries_d >= TRY_LIMIT) begin
        w_state_d = ST_LOCK;
      end
    end
`endif

    // Seeing drop_en low re-arms; starting a drop disarms until the next low.
    if (!drop_en) begin
      w_armed_d = 1'b1;
    end else if (w_drop_start) begin
      w_armed_d = 1'b0;
    end else begin
      w_armed_d = r_armed;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode, computed from the state being entered so that the
  // registered outputs line up with the state register.
  // -------------------------------------------------------------------------
  always_comb begin
    w_msg_d = MSG_OFF;
    case (w_state_d)
      ST_IDLE: begin
        if (!w_ok) begin
          w_msg_d = MSG_HOT;
        end else if (!drop_en) begin
          w_msg_d = MSG_COLD;
        end else begin
          w_msg_d = MSG_WAIT;
        end
      end
      ST_DROP: w_msg_d = MSG_DROP;
      ST_DONE: w_msg_d = MSG_DONE;
`ifdef BAGGAGE_HOT_LOCKOUT_EN
      ST_LOCK: w_msg_d = MSG_LOC;
`endif
      default: w_msg_d = MSG_OFF;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_armed    <= 1'b0;
      r_msg      <= MSG_OFF;
      r_drop_act <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_armed    <= w_armed_d;
      r_msg      <= w_msg_d;
      r_drop_act <= (w_state_d == ST_DROP);
      r_busy     <= (w_state_d == ST_DROP) || (w_state_d == ST_DONE);
    end
  end

`ifdef BAGGAGE_HOT_LOCKOUT_EN
  // Previous drop_en resets high so a request held through reset is not
  // mistaken for a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tries        <= '0;
      r_drop_en_prev <= 1'b1;
    end else begin
      r_tries        <= w_tries_d;
      r_drop_en_prev <= drop_en;
    end
  end
`endif

  assign seven_seg1     = r_msg[27:21];
  assign seven_seg2     = r_msg[20:14];
  assign seven_seg3     = r_msg[13:7];
  assign seven_seg4     = r_msg[6:0];
  assign drop_activated = r_drop_act;
  assign busy           = r_busy;

endmodule
